// File: rtl/softmax_in_buf_pp.sv
// softmax_in_buf_pp: two-slot ping-pong buffer serialising TOUT-lane words into single lanes with padding skip.
// Define SOFTMAX_IN_BUF_MAX_EN to add the per-row signed running maximum outputs (out_max, out_max_vld).
module softmax_in_buf_pp #(
  parameter int TOUT      = 32,
  parameter int DAT_DW    = 16,
  parameter int CH_W      = 16,
  parameter int LOG2_TOUT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH_W-1:0]        ch_in,
  input  logic [CH_W-1:0]        ch_addr,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [TOUT*DAT_DW-1:0] wr_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DAT_DW-1:0]      out_dat,
  output logic [LOG2_TOUT-1:0]   out_lane,
  output logic                   out_last,
  output logic                   out_row_last,
  output logic                   err_drop
`ifdef SOFTMAX_IN_BUF_MAX_EN
  ,
  output logic [DAT_DW-1:0]      out_max,
  output logic                   out_max_vld
`endif
);
  localparam int BW = CH_W + LOG2_TOUT;
  localparam int NW = LOG2_TOUT + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state;
  logic [1:0] r_full, r_row_end;
  logic r_wr_ptr, r_rd_ptr;
  logic [TOUT*DAT_DW-1:0] r_dat [2];
  logic [NW-1:0] r_n [2];
  logic [BW-1:0] w_base, w_ch, w_rem;
  logic [NW-1:0] w_n, w_ld_n;
  logic [LOG2_TOUT-1:0] w_ld_lane;
  logic [TOUT*DAT_DW-1:0] w_ld_word;
  logic w_row_end, w_wr_en, w_store, w_fire, w_done, w_ld, w_ld_byp, w_ld_slot, w_ld_re, w_ld_last;
  assign wr_rdy = ~r_full[r_wr_ptr];
  always_comb begin
    w_base = {ch_addr, {LOG2_TOUT{1'b0}}};
    w_ch = {{LOG2_TOUT{1'b0}}, ch_in};
    w_rem = w_ch - w_base;
    w_n = (w_base >= w_ch) ? '0 : (w_rem >= BW'(TOUT)) ? NW'(TOUT) : w_rem[NW-1:0];
    w_row_end = (w_n != '0) && (w_rem <= BW'(TOUT));
    w_wr_en = wr_vld & wr_rdy;
    w_store = w_wr_en & (w_n != '0);
    w_fire = out_vld & out_rdy;
    w_done = (r_state == SHIFT) & w_fire & out_last;
    // With both slots empty the incoming word feeds the output register directly.
    w_ld_byp = (r_state == IDLE) & ~r_full[r_rd_ptr];
    w_ld_slot = w_done ? ~r_rd_ptr : r_rd_ptr;
    w_ld_lane = (r_state == SHIFT && !out_last) ? out_lane + 1'b1 : '0;
    w_ld_word = w_ld_byp ? wr_dat : r_dat[w_ld_slot];
    w_ld_n = w_ld_byp ? w_n : r_n[w_ld_slot];
    w_ld_re = w_ld_byp ? w_row_end : r_row_end[w_ld_slot];
    w_ld_last = ({1'b0, w_ld_lane} == w_ld_n - 1'b1);
    w_ld = (r_state == IDLE) ? (r_full[r_rd_ptr] | w_store) : (w_fire & (~out_last | r_full[~r_rd_ptr]));
  end
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_dat[r_wr_ptr] <= wr_dat;
      r_n[r_wr_ptr] <= w_n;
      r_row_end[r_wr_ptr] <= w_row_end;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_full <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      out_vld <= 1'b0;
      out_dat <= '0;
      out_lane <= '0;
      out_last <= 1'b0;
      out_row_last <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (w_wr_en && w_n == '0) err_drop <= 1'b1;
      if (w_done) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_store) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_ld) begin
        r_state <= SHIFT;
        out_vld <= 1'b1;
        out_dat <= w_ld_word[w_ld_lane*DAT_DW +: DAT_DW];
        out_lane <= w_ld_lane;
        out_last <= w_ld_last;
        out_row_last <= w_ld_last & w_ld_re;
      end else if (w_done) begin
        r_state <= IDLE;
        out_vld <= 1'b0;
      end
    end
  end
`ifdef SOFTMAX_IN_BUF_MAX_EN
  logic signed [DAT_DW-1:0] r_acc, w_cur;
  logic r_first;
  assign w_cur = (r_first || $signed(out_dat) > r_acc) ? $signed(out_dat) : r_acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_first <= 1'b1;
      out_max <= '0;
      out_max_vld <= 1'b0;
    end else begin
      out_max_vld <= w_fire & out_row_last;
      if (w_fire) begin
        r_acc <= w_cur;
        r_first <= out_row_last;
        if (out_row_last) out_max <= w_cur;
      end
    end
  end
`endif
endmodule

// File: tb/tb_softmax_in_buf_pp.sv
// tb_softmax_in_buf_pp: random and directed stimulus checked against a queue-based lane model.
module tb_softmax_in_buf_pp;
  localparam int TOUT = 32, DW = 16, CW = 16, LT = 5;
  logic clk = 0, rst = 1;
  logic [CW-1:0] ch_in = '0, ch_addr = '0;
  logic wr_vld = 0, wr_rdy, out_vld, out_rdy = 1;
  logic [TOUT*DW-1:0] wr_dat = '0;
  logic [DW-1:0] out_dat;
  logic [LT-1:0] out_lane;
  logic out_last, out_row_last, err_drop;
`ifdef SOFTMAX_IN_BUF_MAX_EN
  logic [DW-1:0] out_max;
  logic out_max_vld;
`endif
  softmax_in_buf_pp #(.TOUT(TOUT), .DAT_DW(DW), .CH_W(CW), .LOG2_TOUT(LT)) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_addr(ch_addr), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .wr_dat(wr_dat), .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_lane(out_lane),
    .out_last(out_last), .out_row_last(out_row_last), .err_drop(err_drop)
`ifdef SOFTMAX_IN_BUF_MAX_EN
    , .out_max(out_max), .out_max_vld(out_max_vld)
`endif
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, fires = 0, pending = 0, rdy_mode = 0;
  bit exp_err = 0;
  logic [DW+LT+1:0] q[$];
`ifdef SOFTMAX_IN_BUF_MAX_EN
  logic signed [DW-1:0] rmax = 0, cur_max;
  logic [DW-1:0] exp_max = 0, last_max = 0;
  bit first = 1, exp_mv = 0;
`endif
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input int ch, input int addr, input logic [TOUT*DW-1:0] d);
    int base, n;
    base = addr * TOUT;
    n = (ch == 0 || base >= ch) ? 0 : (ch - base < TOUT ? ch - base : TOUT);
    if (n == 0) exp_err = 1;
    else begin
      pending++;
      for (int i = 0; i < n; i++) q.push_back({d[i*DW +: DW], LT'(i), i == n-1, i == n-1 && base + n == ch});
    end
  endtask
  always @(negedge clk) begin
    logic [DW+LT+1:0] b;
    if (rst) begin
      chk("rst out_vld", out_vld, 0);
      chk("rst outs", {out_dat, out_lane, out_last, out_row_last}, 0);
      chk("rst err_drop", err_drop, 0);
      chk("rst wr_rdy", wr_rdy, 1);
      q.delete();
      pending = 0;
      exp_err = 0;
`ifdef SOFTMAX_IN_BUF_MAX_EN
      chk("rst max", {out_max, out_max_vld}, 0);
      first = 1;
      exp_mv = 0;
`endif
    end else begin
      chk("wr_rdy", wr_rdy, pending < 2);
      chk("err_drop", err_drop, exp_err);
      if (out_vld) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL spurious beat: got lane %0d data %0h expected none", out_lane, out_dat);
        end else chk("beat {dat,lane,last,row_last}", {out_dat, out_lane, out_last, out_row_last}, q[0]);
      end
`ifdef SOFTMAX_IN_BUF_MAX_EN
      chk("out_max_vld", out_max_vld, exp_mv);
      if (out_max_vld) begin
        chk("out_max", out_max, exp_max);
        last_max = out_max;
      end
      exp_mv = 0;
`endif
      if (out_vld && out_rdy) begin
        fires++;
        if (q.size() > 0) begin
          b = q.pop_front();
          if (b[1]) pending--;
`ifdef SOFTMAX_IN_BUF_MAX_EN
          cur_max = (first || $signed(b[DW+LT+1 -: DW]) > rmax) ? $signed(b[DW+LT+1 -: DW]) : rmax;
          if (b[0]) begin
            exp_max = cur_max;
            exp_mv = 1;
            first = 1;
          end else begin
            rmax = cur_max;
            first = 0;
          end
`endif
        end
      end
      if (wr_vld && wr_rdy) push(int'(ch_in), int'(ch_addr), wr_dat);
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  task automatic wr(input int ch, input int addr, input logic [TOUT*DW-1:0] d);
    int k = 0;
    ch_in = CW'(ch);
    ch_addr = CW'(addr);
    wr_dat = d;
    wr_vld = 1;
    @(negedge clk);
    while (!wr_rdy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("write accepted", wr_rdy, 1);
    @(posedge clk);
    #1;
    wr_vld = 0;
  endtask
  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || out_vld) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain remaining", q.size(), 0);
  endtask
  function automatic logic [TOUT*DW-1:0] rnd_word();
    logic [TOUT*DW-1:0] d;
    for (int i = 0; i < TOUT; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction
  initial begin
    logic [TOUT*DW-1:0] d, d2;
    int f0, k;
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [TOUT*DW-1:0] d, d2;
    int f0, k;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < TOUT; i++) d[i*DW +: DW] = DW'(i);
    f0 = fires;
    wr(32, 0, d);
    chk("t1 latency out_vld", out_vld, 1);
    chk("t1 first lane", {out_dat, out_lane}, 0);
    repeat (32) @(posedge clk);
    #1;
    chk("t1 lane count", fires - f0, 32);
    chk("t1 idle after", out_vld, 0);
    for (int i = 0; i < TOUT; i++) d2[i*DW +: DW] = DW'(100 + i);
    f0 = fires;
    wr(40, 0, d);
    wr(40, 1, d2);
    repeat (39) @(posedge clk);
    #1;
    chk("t2 40 lanes no bubble", fires - f0, 40);
    chk("t2 idle after", out_vld, 0);
    rdy_mode = 2;
    wr(64, 0, rnd_word());
    wr(64, 1, rnd_word());
    d = rnd_word();
    ch_in = 16'd64;
    ch_addr = 16'd0;
    wr_dat = d;
    wr_vld = 1;
    @(negedge clk);
    chk("t3 full wr_rdy", wr_rdy, 0);
    repeat (4) @(negedge clk);
    chk("t3 held lane", {out_vld, out_lane}, {1'b1, 5'd0});
    @(posedge clk);
    #1 rdy_mode = 1;
    wr(64, 0, d);
    drain();
    rdy_mode = 0;
    f0 = fires;
    wr(20, 1, rnd_word());
    repeat (3) @(posedge clk);
    #1;
    chk("t4 err_drop", err_drop, 1);
    chk("t4 no output", fires - f0, 0);
    wr(20, 0, rnd_word());
    drain();
    chk("t4 lanes", fires - f0, 20);
    wr(32, 0, rnd_word());
    k = 0;
    while (out_lane != 5'd10 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5 reached lane 10", out_lane, 10);
    rst = 1;
    #1;
    chk("t5 async clear", {out_vld, out_lane, out_dat, wr_rdy}, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    f0 = fires;
    repeat (6) @(posedge clk);
    #1;
    chk("t5 no stale lanes", fires - f0, 0);
    rdy_mode = 1;
    repeat (40) wr($urandom_range(0, 90), $urandom_range(0, 3), rnd_word());
    drain();
    rdy_mode = 0;
`ifdef SOFTMAX_IN_BUF_MAX_EN
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < TOUT; i++) d[i*DW +: DW] = DW'(i - 5);
    for (int i = 0; i < TOUT; i++) d2[i*DW +: DW] = DW'(27 + i);
    wr(40, 0, d);
    wr(40, 1, d2);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("t6 row max", last_max, 34);
    for (int i = 0; i < TOUT; i++) d[i*DW +: DW] = 16'hFFFD;
    wr(32, 0, d);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("t6 all -3 max", last_max, 16'hFFFD);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
